fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the decode/regfile/alu/writeback pipeline. Issues
//  aligned burst reads on the system bus and splits each 64-bit beat into two 32-bit
//  instructions, low half first. Buffers them in an instruction queue and hands one per
//  cycle to decode with a valid/ready handshake; PC redirects flush the queue and refetch.
// PARAMETERS
//  BUS_DATA_WIDTH  64  bus beat width; fixed at 64 (2 instructions per beat)
//  ADDR_WIDTH      64  byte-address width
//  BURST_BEATS     8   beats per bus read burst (burst = 64 B, 16 instructions)
//  IQ_DEPTH        32  instruction-queue entries; power of 2, >= 2*BURST_BEATS
// PORTS
//  clk             in   1               clock; all state on posedge
//  reset_n         in   1               async active-low reset
//  start           in   1               1-cycle pulse: begin fetching at start_pc
//  start_pc        in   ADDR_WIDTH      entry PC; bits[1:0] ignored
//  redirect_valid  in   1               1-cycle pulse: flush and refetch at redirect_pc
//  redirect_pc     in   ADDR_WIDTH      new PC; bits[1:0] ignored
//  bus_req_valid   out  1               burst read request
//  bus_req_addr    out  ADDR_WIDTH      burst address, 64 B aligned
//  bus_req_ready   in   1               request accepted when valid&ready
//  bus_resp_valid  in   1               response beat valid (never back-pressured)
//  bus_resp_data   in   BUS_DATA_WIDTH  response beat
//  bus_resp_last   in   1               final beat of burst
//  ins_valid       out  1               ins_data/ins_pc valid to decode
//  ins_data        out  32              instruction
//  ins_pc          out  ADDR_WIDTH      instruction address
//  ins_ready       in   1               decode accepts when valid&ready
//  busy            out  1               FSM not IDLE or queue non-empty
// BEHAVIOUR
//  Reset: FSM=IDLE, queue empty, fetch_pc=0; bus_req_valid=0, bus_req_addr=0, ins_valid=0,
//   ins_data=0, ins_pc=0, busy=0. Reset mid-burst drops all state; late beats are ignored.
//  FSM: IDLE -start-> REQ. REQ: assert bus_req_valid when free entries >= 2*BURST_BEATS;
//   addr = fetch_pc & ~63; held stable until accepted -> WAIT. WAIT: each beat k writes
//   words at addr+8k, addr+8k+4; words below fetch_pc are discarded (unaligned entry);
//   on last beat fetch_pc = addr+64 -> REQ. DRAIN: consume beats, write nothing; on last
//   beat -> REQ at the pending redirect PC.
//  Queue: up to 2 pushes and 1 pop per cycle; simultaneous push and pop are legal at any
//   occupancy; the admission rule above guarantees no overflow; pop from empty never occurs.
//  Output: ins_valid = queue non-empty & !redirect_valid; ins_data/ins_pc = head (registered
//   queue storage). Latency: last beat of first accepted burst -> ins_valid next cycle.
//  Redirect (any state except IDLE): queue flushed same edge; a pop in the same cycle is
//   void. REQ -> REQ at new PC; pending unaccepted request is withdrawn. WAIT -> DRAIN
//   (DRAIN stores new PC). Redirect during DRAIN overwrites the pending PC. Redirect in
//   IDLE is ignored. start outside IDLE is ignored. start & redirect together: start wins in IDLE.
//  PC arithmetic is modulo 2^ADDR_WIDTH; a burst at top of memory wraps fetch_pc to 0.
//  No halt detection: fetch continues until reset; decode owns end_of_cycle.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs stat_bursts[31:0] (accepted requests), stat_stall[31:0]
//   (cycles ins_valid&!ins_ready), stat_flush[31:0] (redirects honoured); reset to 0,
//   saturate at 2^32-1. Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  start_pc=0x1000, bus 8 beats, beat0=0xBBBBBBBB_AAAAAAAA -> bus_req_addr=0x1000;
//   ins 0xAAAAAAAA@0x1000 then 0xBBBBBBBB@0x1004; 16 ins in PC order.
//  start_pc=0x1014 -> req 0x1000; first ins_pc=0x1014; 11 ins from burst; next req 0x1040.
//  ins_ready=0 held -> queue fills to 32; no third request issued; release -> 32 ins then req.
//  redirect_pc=0x2000 during beat 3 of WAIT -> beats 4..7 dropped, no ins_valid; next
//   request 0x2000 after last beat; first ins_pc=0x2000.
//  redirect with ins_valid&ins_ready same cycle -> ins_valid=0 that cycle; queue empty next.
//  reset_n low during WAIT beat 2 -> all outputs 0 asynchronously; stays IDLE after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: burst instruction fetch split into a 2-push/1-pop queue feeding decode.
// Define FETCH_STATS_EN to add saturating burst/stall/flush counters.
module fetch_sequencer #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int BURST_BEATS    = 8,
  parameter int IQ_DEPTH       = 32
)(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     start_pc,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      bus_req_valid,
  output logic [ADDR_WIDTH-1:0]     bus_req_addr,
  input  logic                      bus_req_ready,
  input  logic                      bus_resp_valid,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp_data,
  input  logic                      bus_resp_last,
  output logic                      ins_valid,
  output logic [31:0]               ins_data,
  output logic [ADDR_WIDTH-1:0]     ins_pc,
  input  logic                      ins_ready,
  output logic                      busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]               stat_bursts,
  output logic [31:0]               stat_stall,
  output logic [31:0]               stat_flush
`endif
);
  localparam int BB = $clog2(BURST_BEATS);
  localparam int OB = BB + 3;
  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0] MAXOCC = (PW+1)'(IQ_DEPTH - 2*BURST_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_pc_n;
  logic [BB-1:0]         r_beat, w_beat_n;
  logic [PW:0]           r_wr, r_rd, w_count, w_npush;
  logic [31:0]           r_q_data [IQ_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc [IQ_DEPTH];
  logic [PW-1:0]         w_idx0, w_idx1;
  logic [ADDR_WIDTH-1:0] w_start_pc, w_redir_pc, w_next_blk, w_lo_pc, w_hi_pc;
  logic                  w_flush, w_beat, w_push_lo, w_push_hi, w_pop, w_acc, w_nonempty;
  logic                  w_unused;

  assign w_unused   = ^{start_pc[1:0], redirect_pc[1:0], r_fetch_pc[1:0]};
  assign w_count    = r_wr - r_rd;
  assign w_nonempty = w_count != '0;
  assign w_flush    = redirect_valid && r_state != S_IDLE;
  assign w_start_pc = {start_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_next_blk = {r_fetch_pc[ADDR_WIDTH-1:OB] + 1'b1, {OB{1'b0}}};
  assign w_lo_pc    = {r_fetch_pc[ADDR_WIDTH-1:OB], r_beat, 3'b000};
  assign w_hi_pc    = {r_fetch_pc[ADDR_WIDTH-1:OB], r_beat, 3'b100};
  // words of the first burst lying below an unaligned entry PC are skipped
  assign w_beat     = bus_resp_valid && r_state == S_WAIT && !w_flush;
  assign w_push_lo  = w_beat && {r_beat, 1'b0} >= r_fetch_pc[OB-1:2];
  assign w_push_hi  = w_beat && {r_beat, 1'b1} >= r_fetch_pc[OB-1:2];
  assign w_npush    = {{(PW-1){1'b0}}, w_push_lo & w_push_hi, w_push_lo ^ w_push_hi};
  assign w_idx0     = r_wr[PW-1:0];
  assign w_idx1     = w_idx0 + 1'b1;

  assign bus_req_valid = r_state == S_REQ && w_count <= MAXOCC && !redirect_valid;
  assign bus_req_addr  = {r_fetch_pc[ADDR_WIDTH-1:OB], {OB{1'b0}}};
  assign w_acc         = bus_req_valid && bus_req_ready;
  assign ins_valid     = w_nonempty && !redirect_valid;
  assign ins_data      = w_nonempty ? r_q_data[r_rd[PW-1:0]] : '0;
  assign ins_pc        = w_nonempty ? r_q_pc[r_rd[PW-1:0]] : '0;
  assign w_pop         = ins_valid && ins_ready;
  assign busy          = r_state != S_IDLE || w_nonempty;

  // DRAIN has no use for fetch_pc, so it holds the pending redirect target
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_fetch_pc;
    w_beat_n  = r_beat;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_n = S_REQ;
        w_pc_n    = w_start_pc;
      end
      S_REQ: if (w_flush) w_pc_n = w_redir_pc;
        else if (w_acc) begin
          w_state_n = S_WAIT;
          w_beat_n  = '0;
        end
      S_WAIT: if (w_flush) begin
          w_pc_n    = w_redir_pc;
          w_state_n = (bus_resp_valid && bus_resp_last) ? S_REQ : S_DRAIN;
        end else if (bus_resp_valid) begin
          w_beat_n = r_beat + 1'b1;
          if (bus_resp_last) begin
            w_state_n = S_REQ;
            w_pc_n    = w_next_blk;
          end
        end
      S_DRAIN: begin
        if (w_flush) w_pc_n = w_redir_pc;
        if (bus_resp_valid && bus_resp_last) w_state_n = S_REQ;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_beat     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_state    <= w_state_n;
      r_fetch_pc <= w_pc_n;
      r_beat     <= w_beat_n;
      r_wr       <= w_flush ? '0 : r_wr + w_npush;
      r_rd       <= w_flush ? '0 : r_rd + {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_lo || w_push_hi) begin
      r_q_data[w_idx0] <= w_push_lo ? bus_resp_data[31:0] : bus_resp_data[63:32];
      r_q_pc[w_idx0]   <= w_push_lo ? w_lo_pc : w_hi_pc;
    end
    if (w_push_lo && w_push_hi) begin
      r_q_data[w_idx1] <= bus_resp_data[63:32];
      r_q_pc[w_idx1]   <= w_hi_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_bursts, r_stat_stall, r_stat_flush;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_bursts <= '0;
      r_stat_stall  <= '0;
      r_stat_flush  <= '0;
    end else begin
      if (w_acc && ~&r_stat_bursts) r_stat_bursts <= r_stat_bursts + 1'b1;
      if (ins_valid && !ins_ready && ~&r_stat_stall) r_stat_stall <= r_stat_stall + 1'b1;
      if (w_flush && ~&r_stat_flush) r_stat_flush <= r_stat_flush + 1'b1;
    end
  end
  assign stat_bursts = r_stat_bursts;
  assign stat_stall  = r_stat_stall;
  assign stat_flush  = r_stat_flush;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus random stimulus against a bus memory model and
// an expected-PC-stream scoreboard.
module tb_fetch_sequencer;
  logic        clk = 0;
  logic        reset_n, start, redirect_valid, bus_req_valid, bus_req_ready;
  logic        bus_resp_valid, bus_resp_last, ins_valid, ins_ready, busy;
  logic [63:0] start_pc, redirect_pc, bus_req_addr, bus_resp_data, ins_pc;
  logic [31:0] ins_data;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_bursts, stat_stall, stat_flush;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_ready(bus_req_ready),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_resp_last(bus_resp_last),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .busy(busy)
`ifdef FETCH_STATS_EN
    , .stat_bursts(stat_bursts), .stat_stall(stat_stall), .stat_flush(stat_flush)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == 64'h1000) return 32'hAAAAAAAA;
    if (a == 64'h1004) return 32'hBBBBBBBB;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  logic [63:0] sl_q[$];
  logic [2:0]  sl_beat, sl_cur;
  logic [63:0] sl_ba;
  logic        bus_kill = 0;

  initial begin
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = 0; bus_resp_last = 0;
    sl_beat = 0; sl_cur = 0;
    forever begin
      @(negedge clk);
      if (bus_kill) begin sl_q.delete(); sl_beat = 0; end
      bus_req_ready = $urandom_range(0, 3) != 0;
      if (sl_q.size() != 0 && $urandom_range(0, 4) != 0) begin
        sl_ba = sl_q[0] + {58'd0, sl_beat, 3'd0};
        sl_cur = sl_beat;
        bus_resp_valid = 1;
        bus_resp_data = {mem(sl_ba + 64'd4), mem(sl_ba)};
        bus_resp_last = sl_beat == 3'd7;
        if (sl_beat == 3'd7) void'(sl_q.pop_front());
        sl_beat = sl_beat + 3'd1;
      end else begin
        bus_resp_valid = 0;
        bus_resp_last = 0;
      end
      #1;
      if (reset_n && bus_req_valid && bus_req_ready) sl_q.push_back(bus_req_addr);
    end
  end

  logic        running = 0;
  logic [63:0] exp_pc, req_exp;
  int          n_pop = 0, n_req = 0;
  logic [63:0] pop_pc_log[$], req_log[$];
  logic [31:0] pop_dat_log[$];
  int          req_pop_log[$];

  initial forever begin
    @(negedge clk);
    #1;
    if (!reset_n) running = 0;
    else begin
      if (!running) begin
        chk("idle_busy", busy, 0);
        chk("idle_ins_valid", ins_valid, 0);
        if (start) begin
          running = 1;
          exp_pc  = {start_pc[63:2], 2'b00};
          req_exp = {start_pc[63:6], 6'b0};
        end
      end else if (redirect_valid) begin
        exp_pc  = {redirect_pc[63:2], 2'b00};
        req_exp = {redirect_pc[63:6], 6'b0};
        chk("redir_ins_valid", ins_valid, 0);
        chk("redir_req_valid", bus_req_valid, 0);
      end
      if (ins_valid && ins_ready) begin
        chk("ins_pc", ins_pc, exp_pc);
        chk("ins_data", {32'd0, ins_data}, {32'd0, mem(exp_pc)});
        pop_pc_log.push_back(ins_pc);
        pop_dat_log.push_back(ins_data);
        exp_pc = exp_pc + 64'd4;
        n_pop++;
      end
      if (bus_req_valid && bus_req_ready) begin
        chk("req_addr", bus_req_addr, req_exp);
        req_log.push_back(bus_req_addr);
        req_pop_log.push_back(n_pop);
        req_exp = req_exp + 64'd64;
        n_req++;
      end
    end
  end

  task automatic clear_logs();
    pop_pc_log.delete(); pop_dat_log.delete(); req_log.delete(); req_pop_log.delete();
    n_pop = 0; n_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; bus_kill = 1; start = 0; redirect_valid = 0;
    repeat (3) @(negedge clk);
    clear_logs();
    reset_n = 1; bus_kill = 0;
  endtask

  task automatic pulse_start(input logic [63:0] pc);
    @(negedge clk); start = 1; start_pc = pc;
    @(negedge clk); start = 0;
  endtask

  task automatic pulse_redir(input logic [63:0] pc);
    @(negedge clk); redirect_valid = 1; redirect_pc = pc;
    @(negedge clk); redirect_valid = 0;
  endtask

  task automatic wait_req(input int n, input string tag);
    int t = 0;
    while (n_req < n && t < 2000) begin @(negedge clk); #2; t++; end
    chk(tag, 64'(n_req >= n), 1);
  endtask

  task automatic wait_pop(input int n, input string tag);
    int t = 0;
    while (n_pop < n && t < 2000) begin @(negedge clk); #2; t++; end
    chk(tag, 64'(n_pop >= n), 1);
  endtask

  task automatic wait_beat(input logic [2:0] k, input logic last, input string tag);
    int t = 0;
    do begin @(negedge clk); #2; t++; end
    while (!(bus_resp_valid && (last ? bus_resp_last : sl_cur == k)) && t < 2000);
    chk(tag, 64'(t < 2000), 1);
  endtask

  initial begin
    int nb, np, iv, t;
    reset_n = 0; start = 0; start_pc = 0; redirect_valid = 0; redirect_pc = 0; ins_ready = 0;
    #3;
    chk("rst_req_valid", bus_req_valid, 0);
    chk("rst_req_addr", bus_req_addr, 0);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins_data", {32'd0, ins_data}, 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // aligned entry, decode stalled: latency, head word order, fill limit
    pulse_start(64'h1000);
    wait_req(1, "t1_req1");
    chk("t1_req1_addr", req_log[0], 64'h1000);
    wait_beat(0, 1, "t1_last");
    @(negedge clk); #2;
    chk("t1_lat_valid", ins_valid, 1);
    chk("t1_head_pc", ins_pc, 64'h1000);
    chk("t1_head_data", {32'd0, ins_data}, 64'hAAAAAAAA);
    repeat (300) @(negedge clk);
    #2;
    chk("t1_nreq_full", n_req, 2);
    chk("t1_no_req3", bus_req_valid, 0);
    chk("t1_head_still", ins_pc, 64'h1000);
    @(negedge clk); ins_ready = 1;
    wait_pop(32, "t1_pop32");
    chk("t1_pop1_pc", pop_pc_log[1], 64'h1004);
    chk("t1_pop1_data", {32'd0, pop_dat_log[1]}, 64'hBBBBBBBB);
    chk("t1_pop31_pc", pop_pc_log[31], 64'h107C);
    wait_req(3, "t1_req3");
    chk("t1_req3_addr", req_log[2], 64'h1080);
    chk("t1_req3_admit", 64'(req_pop_log[2] >= 16), 1);

    // unaligned entry
    do_reset();
    pulse_start(64'h1014);
    wait_pop(12, "t2_pop12");
    chk("t2_req1", req_log[0], 64'h1000);
    chk("t2_first_pc", pop_pc_log[0], 64'h1014);
    chk("t2_11th_pc", pop_pc_log[10], 64'h103C);
    chk("t2_12th_pc", pop_pc_log[11], 64'h1040);
    wait_req(2, "t2_req2");
    chk("t2_req2_addr", req_log[1], 64'h1040);

    // redirect in WAIT after beat 3
    do_reset();
    pulse_start(64'h1000);
    wait_beat(3, 0, "t3_beat3");
    nb = n_req;
    pulse_redir(64'h2000);
    iv = 0; t = 0;
    while (n_req == nb && t < 2000) begin @(negedge clk); #2; if (ins_valid) iv++; t++; end
    chk("t3_no_ins_drain", iv, 0);
    chk("t3_req_new", req_log[req_log.size()-1], 64'h2000);
    np = n_pop;
    wait_pop(np + 1, "t3_pop");
    chk("t3_first_pc", pop_pc_log[np], 64'h2000);

    // redirect coinciding with a pop
    ins_ready = 0;
    repeat (40) @(negedge clk);
    #2;
    chk("t4_pre_valid", ins_valid, 1);
    @(negedge clk); ins_ready = 1; redirect_valid = 1; redirect_pc = 64'h300B;
    #2;
    chk("t4_void_pop", ins_valid, 0);
    @(negedge clk); redirect_valid = 0;
    #2;
    chk("t4_empty_next", ins_valid, 0);
    np = n_pop;
    wait_pop(np + 1, "t4_pop");
    chk("t4_first_pc", pop_pc_log[np], 64'h3008);

    // asynchronous reset during beat 2, late beats ignored
    do_reset();
    pulse_start(64'h4000);
    wait_beat(2, 0, "t5_beat2");
    #1 reset_n = 0;
    #1;
    chk("t5_req_valid", bus_req_valid, 0);
    chk("t5_req_addr", bus_req_addr, 0);
    chk("t5_ins_valid", ins_valid, 0);
    chk("t5_ins_data", {32'd0, ins_data}, 0);
    chk("t5_ins_pc", ins_pc, 0);
    chk("t5_busy", busy, 0);
    clear_logs();
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (20) @(negedge clk);
    pulse_redir(64'h5000);
    repeat (3) @(negedge clk);
    #2;
    chk("t5_idle_busy", busy, 0);
    chk("t5_no_req", n_req, 0);
    bus_kill = 1;
    @(negedge clk); bus_kill = 0;

    // wrap at top of memory, then random traffic
    do_reset();
    pulse_start(64'hFFFF_FFFF_FFFF_FFF8);
    wait_req(2, "t6_req2");
    chk("t6_req_top", req_log[0], 64'hFFFF_FFFF_FFFF_FFC0);
    chk("t6_req_wrap", req_log[1], 64'h0);
    wait_pop(4, "t6_pop4");
    chk("t6_wrap_pc", pop_pc_log[2], 64'h0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ins_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 99) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? {32'hFFFFFFFF, $urandom} : {32'd0, $urandom};
      start = $urandom_range(0, 199) == 0;
      start_pc = {$urandom, $urandom};
    end
    @(negedge clk); redirect_valid = 0; start = 0;
    #2;
    chk("t6_progress", 64'(n_pop > 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
